// File: rtl/render_pkg.sv
// Shared types and constants for the render scheduler.
package render_pkg;
  localparam int MAX_PTS = 64;

  typedef logic [7:0]  coord_t;
  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    IDLE, CLEAR, POINTS, SEG_ISSUE, SEG_WAIT, FIN
  } state_t;

  localparam rgb_t BLACK = 24'h000000;
  localparam rgb_t WHITE = 24'hFFFFFF;
endpackage

// File: rtl/render_fb_mux.sv
// Framebuffer port: registered sequencer write plus registered select that passes
// the rasterizer's writes straight through while a segment is being drawn.
module render_fb_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_ras_d_i,
  input  logic        seq_we_d_i,
  input  logic [7:0]  seq_x_d_i,
  input  logic [7:0]  seq_y_d_i,
  input  logic [23:0] seq_rgb_d_i,
  input  logic        ras_we_i,
  input  logic [7:0]  ras_x_i,
  input  logic [7:0]  ras_y_i,
  input  logic [23:0] ras_rgb_i,
  output logic        fb_we_o,
  output logic [7:0]  fb_x_o,
  output logic [7:0]  fb_y_o,
  output logic [23:0] fb_rgb_o
);
  logic        sel_q;
  logic        we_q;
  logic [7:0]  x_q, y_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
      we_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
    end else begin
      sel_q <= sel_ras_d_i;
      we_q  <= seq_we_d_i;
      x_q   <= seq_x_d_i;
      y_q   <= seq_y_d_i;
      rgb_q <= seq_rgb_d_i;
    end
  end

  always_comb begin
    fb_we_o  = we_q;
    fb_x_o   = x_q;
    fb_y_o   = y_q;
    fb_rgb_o = rgb_q;
    if (sel_q) begin
      fb_we_o  = ras_we_i;
      fb_x_o   = ras_x_i;
      fb_y_o   = ras_y_i;
      fb_rgb_o = ras_rgb_i;
    end
  end
endmodule

// File: rtl/render_sched.sv
// Frame sequencer: optional background clear, point plotting, then path segments
// handed to an external line rasterizer. Clear phase built only with RENDER_SCHED_CLEAR_EN.
module render_sched import render_pkg::*; #(
  parameter int          NPTS      = 64,
  parameter logic [23:0] CLR_COLOR = WHITE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         num_pts,
  input  logic [NPTS*8-1:0]  xs,
  input  logic [NPTS*8-1:0]  ys,
  input  logic [NPTS*6-1:0]  path,
  output logic               ln_valid,
  input  logic               ln_ready,
  output logic [7:0]         ln_x0,
  output logic [7:0]         ln_y0,
  output logic [7:0]         ln_x1,
  output logic [7:0]         ln_y1,
  output logic [7:0]         ln_b,
  input  logic               ln_done,
  input  logic               ras_we,
  input  logic [7:0]         ras_x,
  input  logic [7:0]         ras_y,
  input  logic [23:0]        ras_rgb,
  output logic               fb_we,
  output logic [7:0]         fb_x,
  output logic [7:0]         fb_y,
  output logic [23:0]        fb_rgb,
  output logic               busy,
  output logic               done
);
  state_t     state_q, state_d;
  logic [6:0] n_q, n_d, n_start;
  logic [5:0] i_q, i_d, k_q, k_d;
`ifdef RENDER_SCHED_CLEAR_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic   seq_we;
  coord_t seq_x, seq_y;
  rgb_t   seq_rgb;
  logic   ld_seg;
  logic [5:0] pa, pb;
  coord_t x0_q, y0_q, x1_q, y1_q, b_q;

  function automatic coord_t pt_x(input logic [5:0] idx);
    return xs[int'(idx)*8 +: 8];
  endfunction

  function automatic coord_t pt_y(input logic [5:0] idx);
    return ys[int'(idx)*8 +: 8];
  endfunction

  function automatic logic [5:0] path_at(input logic [5:0] idx);
    return path[int'(idx)*6 +: 6];
  endfunction

  assign n_start = (num_pts > 7'(NPTS)) ? 7'(NPTS) : num_pts;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    k_d     = k_q;
`ifdef RENDER_SCHED_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        n_d = n_start;
        i_d = '0;
        k_d = '0;
`ifdef RENDER_SCHED_CLEAR_EN
        cnt_d   = '0;
        state_d = CLEAR;
`else
        state_d = (n_start == 7'd0) ? FIN : POINTS;
`endif
      end
`ifdef RENDER_SCHED_CLEAR_EN
      CLEAR: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'hFFFF) state_d = (n_q == 7'd0) ? FIN : POINTS;
      end
`endif
      POINTS: begin
        if ({1'b0, i_q} == n_q - 7'd1) begin
          state_d = (n_q <= 7'd1) ? FIN : SEG_ISSUE;
          k_d     = '0;
        end else begin
          i_d = i_q + 6'd1;
        end
      end
      SEG_ISSUE: if (ln_ready) state_d = SEG_WAIT;
      // ln_done is only honoured here, so a pulse coincident with the transfer is lost
      SEG_WAIT: if (ln_done) begin
        if ({1'b0, k_q} + 7'd1 == n_q - 7'd1) begin
          state_d = FIN;
        end else begin
          k_d     = k_q + 6'd1;
          state_d = SEG_ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer write is computed for the upcoming state so fb_we lines up with it
  always_comb begin
    seq_we  = 1'b0;
    seq_x   = '0;
    seq_y   = '0;
    seq_rgb = BLACK;
    if (state_d == POINTS) begin
      seq_we = 1'b1;
      seq_x  = pt_x(i_d);
      seq_y  = pt_y(i_d);
    end
`ifdef RENDER_SCHED_CLEAR_EN
    if (state_d == CLEAR) begin
      seq_we  = 1'b1;
      seq_x   = cnt_d[15:8];
      seq_y   = cnt_d[7:0];
      seq_rgb = CLR_COLOR;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
`ifdef RENDER_SCHED_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      k_q     <= k_d;
`ifdef RENDER_SCHED_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Endpoints are captured on entry to SEG_ISSUE and held through any stall
  assign ld_seg = (state_d == SEG_ISSUE) && (state_q != SEG_ISSUE);
  assign pa     = path_at(k_d);
  assign pb     = path_at(k_d + 6'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      b_q  <= '0;
    end else if (ld_seg) begin
      x0_q <= pt_x(pa);
      y0_q <= pt_y(pa);
      x1_q <= pt_x(pb);
      y1_q <= pt_y(pb);
      b_q  <= {k_d, 2'b00};
    end
  end

  assign ln_valid = (state_q == SEG_ISSUE);
  assign ln_x0    = x0_q;
  assign ln_y0    = y0_q;
  assign ln_x1    = x1_q;
  assign ln_y1    = y1_q;
  assign ln_b     = b_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);

  render_fb_mux u_fb_mux (
    .clk         (clk),
    .rst         (rst),
    .sel_ras_d_i (state_d == SEG_WAIT),
    .seq_we_d_i  (seq_we),
    .seq_x_d_i   (seq_x),
    .seq_y_d_i   (seq_y),
    .seq_rgb_d_i (seq_rgb),
    .ras_we_i    (ras_we),
    .ras_x_i     (ras_x),
    .ras_y_i     (ras_y),
    .ras_rgb_i   (ras_rgb),
    .fb_we_o     (fb_we),
    .fb_x_o      (fb_x),
    .fb_y_o      (fb_y),
    .fb_rgb_o    (fb_rgb)
  );
endmodule

// File: tb/tb_render_sched.sv
// Directed bench for render_sched: vector table of frame shapes plus hand sequences
// for stall, reset mid-segment, restart-while-busy and the optional clear phase.
module tb_render_sched;
  localparam int          NPTS     = 64;
  localparam logic [23:0] RAS_RGB  = 24'h00FF00;
  localparam logic [23:0] SPAM_RGB = 24'hABCDEF;
  localparam logic [23:0] CLR      = 24'hFFFFFF;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [6:0]        num_pts;
  logic [NPTS*8-1:0] xs, ys;
  logic [NPTS*6-1:0] path;
  logic              ln_valid, ln_ready, ln_done;
  logic [7:0]        ln_x0, ln_y0, ln_x1, ln_y1, ln_b;
  logic              ras_we;
  logic [7:0]        ras_x, ras_y;
  logic [23:0]       ras_rgb;
  logic              fb_we;
  logic [7:0]        fb_x, fb_y;
  logic [23:0]       fb_rgb;
  logic              busy, done;

  render_sched #(.NPTS(NPTS), .CLR_COLOR(CLR)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pts(num_pts),
    .xs(xs), .ys(ys), .path(path),
    .ln_valid(ln_valid), .ln_ready(ln_ready),
    .ln_x0(ln_x0), .ln_y0(ln_y0), .ln_x1(ln_x1), .ln_y1(ln_y1), .ln_b(ln_b),
    .ln_done(ln_done),
    .ras_we(ras_we), .ras_x(ras_x), .ras_y(ras_y), .ras_rgb(ras_rgb),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_rgb(fb_rgb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] xs_tab [NPTS];
  logic [7:0] ys_tab [NPTS];
  logic [5:0] path_tab [NPTS];

  int  r_lat, r_wr, r_ras, r_other, r_white, r_white_bad, r_bad_pt, r_bad_seg;
  int  r_unstable, r_busy_bad, r_xfers;
  bit  r_fin;
  bit  ras_spam = 1'b0;
  logic [39:0] segs [$];

  typedef struct {
    int np; int stall; bit dox;
    int exp_wr; int exp_seg; int exp_lat;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [39:0] seg_model(input int k);
    logic [5:0] a, b, kk;
    kk = 6'(k);
    a  = path_tab[kk];
    b  = path_tab[kk + 6'd1];
    return {xs_tab[a], ys_tab[a], xs_tab[b], ys_tab[b], kk, 2'b00};
  endfunction

  // Called right after a negedge; acts as the rasterizer and records every fb write.
  task automatic run_frame(input int np, input int stall, input int restart_at,
                           input int abort_at, input bit dox, input int budget);
    int cyc, cd, stall_left, nexp;
    logic [39:0] held, cur;
    bit hv, xfer;
    nexp = (np > NPTS) ? NPTS : np;
    r_lat = 0; r_wr = 0; r_ras = 0; r_other = 0; r_white = 0; r_white_bad = 0;
    r_bad_pt = 0; r_bad_seg = 0; r_unstable = 0; r_busy_bad = 0; r_xfers = 0;
    r_fin = 1'b0; segs.delete();
    cyc = 0; cd = 0; stall_left = stall; hv = 1'b0; held = '0;
    num_pts = 7'(np);
    start = 1'b1;
    while (!r_fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (!busy) r_busy_bad++;
      if (fb_we) begin
        if (fb_rgb == 24'h000000) begin
          if (!(r_wr < nexp && fb_x == xs_tab[r_wr] && fb_y == ys_tab[r_wr])) r_bad_pt++;
          r_wr++;
        end else if (fb_rgb == RAS_RGB) begin
          if (fb_x != 8'h77 || fb_y != 8'h66) r_bad_pt++;
          r_ras++;
        end else if (fb_rgb == CLR) begin
          if ({fb_x, fb_y} != r_white[15:0]) r_white_bad++;
          r_white++;
        end else begin
          r_other++;
        end
      end
      xfer = 1'b0;
      if (ln_valid) begin
        cur = {ln_x0, ln_y0, ln_x1, ln_y1, ln_b};
        if (hv && cur != held) r_unstable++;
        held = cur; hv = 1'b1;
        if (stall_left > 0) begin
          ln_ready = 1'b0;
          stall_left--;
        end else begin
          ln_ready = 1'b1;
          xfer = 1'b1;
          if (cur != seg_model(r_xfers)) r_bad_seg++;
          segs.push_back(cur);
          r_xfers++;
          hv = 1'b0;
        end
      end else begin
        ln_ready = 1'b0;
        hv = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        ln_done = (cd == 0);
      end else begin
        ln_done = 1'b0;
      end
      if (xfer) begin
        cd = 4;
        ln_done = dox;
      end
      ras_we  = (cd == 2) || ras_spam;
      ras_x   = 8'h77;
      ras_y   = 8'h66;
      ras_rgb = (cd == 2) ? RAS_RGB : SPAM_RGB;
      if (done) begin
        r_lat = cyc;
        r_fin = 1'b1;
      end
      if (cyc == abort_at) begin
        rst = 1'b1;
        r_fin = 1'b1;
      end
    end
    check("frame_timeout", r_fin, 1);
    start = 1'b0; ln_ready = 1'b0; ln_done = 1'b0; ras_we = ras_spam;
  endtask

  task automatic idle_cycles(input int n);
    int nb;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || fb_we || ln_valid || done) nb++;
    end
    check("idle_quiet", nb, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_pts = '0; ln_ready = 1'b0; ln_done = 1'b0;
    ras_we = 1'b0; ras_x = '0; ras_y = '0; ras_rgb = '0;
    for (int i = 0; i < NPTS; i++) begin
      xs_tab[i]   = 8'((10 * (i + 1)) & 255);
      ys_tab[i]   = 8'((10 * i + 5) & 255);
      path_tab[i] = 6'((i * 37 + 2) & 63);
    end
    path_tab[0] = 6'd2; path_tab[1] = 6'd0; path_tab[2] = 6'd1;
    for (int i = 0; i < NPTS; i++) begin
      xs[i*8 +: 8]   = xs_tab[i];
      ys[i*8 +: 8]   = ys_tab[i];
      path[i*6 +: 6] = path_tab[i];
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ln_valid", ln_valid, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_data", {fb_x, fb_y, fb_rgb}, 0);
    check("rst_ln_data", {ln_x0, ln_y0, ln_x1, ln_y1, ln_b}, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef RENDER_SCHED_CLEAR_EN
    run_frame(0, 0, 0, 0, 1'b0, 70000);
    check("clr_white_count", r_white, 65536);
    check("clr_order", r_white_bad, 0);
    check("clr_latency", r_lat, 65537);
    check("clr_no_segments", r_xfers, 0);
    check("clr_no_black", r_wr, 0);
    check("clr_busy", r_busy_bad, 0);
    idle_cycles(3);
`else
    //       np  stall dox  wr  seg  lat
    vecs[0] = '{0,   0,  0,  0,  0,   1};
    vecs[1] = '{1,   0,  0,  1,  0,   2};
    vecs[2] = '{2,   0,  0,  2,  1,   8};
    vecs[3] = '{3,   0,  0,  3,  2,  14};
    vecs[4] = '{3,  10,  1,  3,  2,  24};
    vecs[5] = '{5,   0,  0,  5,  4,  26};
    vecs[6] = '{64,  0,  0, 64, 63, 380};
    vecs[7] = '{100, 0,  0, 64, 63, 380};
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].np, vecs[v].stall, 0, 0, vecs[v].dox, 1000);
      check($sformatf("v%0d_latency", v), r_lat, vecs[v].exp_lat);
      check($sformatf("v%0d_points", v), r_wr, vecs[v].exp_wr);
      check($sformatf("v%0d_segments", v), r_xfers, vecs[v].exp_seg);
      check($sformatf("v%0d_ras_writes", v), r_ras, vecs[v].exp_seg);
      check($sformatf("v%0d_point_xy", v), r_bad_pt, 0);
      check($sformatf("v%0d_seg_fields", v), r_bad_seg, 0);
      check($sformatf("v%0d_stable", v), r_unstable, 0);
      check($sformatf("v%0d_busy", v), r_busy_bad, 0);
      check($sformatf("v%0d_stray", v), r_other + r_white, 0);
      if (v == 3) begin
        check("n3_seg0", (segs.size() > 0) ? segs[0] : 40'h0,
              {8'd30, 8'd25, 8'd10, 8'd5, 8'd0});
        check("n3_seg1", (segs.size() > 1) ? segs[1] : 40'h0,
              {8'd10, 8'd5, 8'd20, 8'd15, 8'd4});
      end
      idle_cycles(2);
    end

    // reset while the rasterizer is drawing the first segment
    run_frame(3, 0, 0, 6, 1'b0, 1000);
    check("abort_in_wait", r_xfers, 1);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_fb_we", fb_we, 0);
    check("abort_ln_valid", ln_valid, 0);
    check("abort_done", done, 0);
    check("abort_ln_data", {ln_x0, ln_y0, ln_x1, ln_y1, ln_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(3, 0, 0, 0, 1'b0, 1000);
    check("rerun_latency", r_lat, 14);
    check("rerun_points", r_wr, 3);
    check("rerun_segments", r_xfers, 2);
    check("rerun_seg_fields", r_bad_seg, 0);
    idle_cycles(2);

    // second start mid-POINTS with an over-range count
    run_frame(100, 0, 5, 0, 1'b0, 1000);
    check("restart_latency", r_lat, 380);
    check("restart_segments", r_xfers, 63);
    check("restart_points", r_wr, 64);
    idle_cycles(2);

    // rasterizer writes outside SEG_WAIT, and start coincident with done
    ras_spam = 1'b1;
    ras_we = 1'b1;
    run_frame(1, 0, 0, 0, 1'b0, 1000);
    check("spam_latency", r_lat, 2);
    check("spam_points", r_wr, 1);
    check("spam_dropped", r_other, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ras_spam = 1'b0;
    ras_we = 1'b0;
    check("start_on_done_busy", busy, 0);
    idle_cycles(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/render_sched.md
RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 SHALL have parameter NPTS, default 64, the point/path table depth (power of two, max 64).
REQ-002 SHALL have parameter CLR_COLOR, default 24'hFFFFFF, the background colour {R,G,B}.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request to render a frame.
REQ-006 num_pts  in  7  count of valid points and path entries (0..64).
REQ-007 xs, ys  in  NPTS x 8  point coordinate tables.
REQ-008 path  in  NPTS x 6  visiting order (point indices).
REQ-009 ln_valid / ln_ready  out / in  1 / 1  segment-command handshake to line rasterizer.
REQ-010 ln_x0, ln_y0, ln_x1, ln_y1  out  8 each  segment endpoints.
REQ-011 ln_b  out  8  segment blue value.
REQ-012 ln_done  in  1  one-cycle pulse when the rasterizer finishes the segment.
REQ-013 ras_we, ras_x, ras_y, ras_rgb  in  1, 8, 8, 24  rasterizer pixel writes.
REQ-014 fb_we, fb_x, fb_y, fb_rgb  out  1, 8, 8, 24  framebuffer write port.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, POINTS, SEG_ISSUE, SEG_WAIT, FIN.
REQ-018 IDLE: start=1 SHALL latch min(num_pts,NPTS) as N and go to CLEAR; start in any other state SHALL be ignored.
REQ-019 CLEAR: 16-bit counter {x,y}; one fb write of CLR_COLOR per cycle; exactly 65536 cycles; wrap 16'hFFFF to POINTS.
REQ-020 POINTS: i = 0..N-1; one write per cycle of 24'h000000 at (xs[i],ys[i]); N=0 goes directly to FIN.
REQ-021 After POINTS, N<=1 SHALL go to FIN; otherwise go to SEG_ISSUE with k=0.
REQ-022 SEG_ISSUE: ln_valid=1, with endpoints (xs[path[k]],ys[path[k]]) -> (xs[path[k+1]],ys[path[k+1]]) and ln_b={k[5:0],2'b00}; fields SHALL be stable while ln_valid && !ln_ready; transfer on ln_valid && ln_ready moves to SEG_WAIT.
REQ-023 SEG_WAIT: ln_valid=0 and fb port muxed from ras_*; ln_done SHALL increment k and return to SEG_ISSUE, or go to FIN when k+1 == N-1.
REQ-024 ln_done in the same cycle as the transfer SHALL be ignored (no segment is counted twice).
REQ-025 ras_we outside SEG_WAIT SHALL be dropped; fb_we SHALL be 0 in IDLE, SEG_ISSUE and FIN.
REQ-026 FIN: done=1 for one cycle, then IDLE; start coincident with done is ignored.
REQ-027 Segment count SHALL be N-1; wrap from the last point back to path[0] is excluded.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 rst SHALL force IDLE, clear all counters and set busy, done, ln_valid and fb_we to 0 on the next edge, including mid-frame and mid-handshake.
REQ-030 Data outputs (fb_x/y/rgb, ln_x*/y*/b) SHALL reset to 0.

Configuration
REQ-031 Macro RENDER_SCHED_CLEAR_EN defined: CLEAR phase present as in REQ-019.
REQ-032 Macro RENDER_SCHED_CLEAR_EN undefined: IDLE goes directly to POINTS; CLR_COLOR unused; no clear counter logic.

Structure
REQ-033 Package render_pkg SHALL hold the state enum, coord_t (8-bit), rgb_t (24-bit), and the black and white constants.
REQ-034 Sub-module render_fb_mux SHALL implement the registered framebuffer-port selection between sequencer and rasterizer.

Verification
REQ-035 CLEAR_EN, N=0, start -> 65536 white writes ((0,0) first, (255,255) last) then done; no ln_valid.
REQ-036 N=3, xs={10,20,30}, ys={5,15,25}, path={2,0,1}; ln_ready=1; ln_done 4 cycles after each transfer -> 3 black writes, segments (30,25)->(10,5) b=0 and (10,5)->(20,15) b=4, then done.
REQ-037 ln_ready held low 10 cycles -> ln_valid and fields stable for all 10 cycles, exactly one transfer.
REQ-038 rst asserted in SEG_WAIT -> next cycle IDLE, busy=0, fb_we=0; new start renders the full frame.
REQ-039 start pulsed mid-POINTS, num_pts=100 -> start ignored; N clamped to 64; 63 segments issued.
REQ-040 CLEAR_EN undefined, N=1 -> one black write, done two cycles after start, no fb writes outside POINTS.
